pad_scan_ctrl: RTL and testbench

PAD_SCAN_CTRL -- requirements
Module: pad_scan_ctrl

---
 rtl/pad_scan_pkg.sv | 28 ++
 rtl/pad_debounce.sv | 50 +++++
 rtl/pad_scan_ctrl.sv | 95 +++++++++
 tb/tb_pad_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_scan_pkg.sv
// pad_scan_pkg: shared definitions for the pad scanner.
//   REG_IOA / REG_IOB : PSG register numbers that map to pad 0 / pad 1
//   PAD_IDLE          : byte seen when no key is pressed (active-low matrix)
//   rd_state_t        : read FSM state encoding
//   resp_byte()       : selects the byte returned for a register number
package pad_scan_pkg;

  localparam logic [3:0] REG_IOA  = 4'd14;
  localparam logic [3:0] REG_IOB  = 4'd15;
  localparam logic [7:0] PAD_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_RESP = 2'd2
  } rd_state_t;

  function automatic logic [7:0] resp_byte(input logic [3:0] reg_num,
                                           input logic [7:0] pad0,
                                           input logic [7:0] pad1);
    logic [7:0] b;
    b = PAD_IDLE;
    if (reg_num == REG_IOA) b = pad0;
    else if (reg_num == REG_IOB) b = pad1;
    return b;
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// pad_debounce: debounces one 8-bit active-low pad byte.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : sample enable; the counter only advances on tick
//   raw        : raw pad byte (may change at any cycle)
//   stable     : debounced byte
//   changed    : one-cycle pulse, high in the first cycle stable shows a new value
module pad_debounce
  import pad_scan_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] raw,
  output logic [7:0] stable,
  output logic       changed
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_N - 1);

  logic [7:0] cand;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cand    <= PAD_IDLE;
      cnt     <= 4'd0;
      stable  <= PAD_IDLE;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      // Any difference restarts the run, tick or not.
      if (raw != cand) begin
        cand <= raw;
        cnt  <= 4'd0;
      end else if (tick) begin
        // This tick either reaches CNT_MAX or holds there: commit the candidate.
        if (cnt >= CNT_MAX - 4'd1) begin
          cnt     <= CNT_MAX;
          stable  <= cand;
          changed <= (cand != stable);
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pad_scan_ctrl.sv
// pad_scan_ctrl: two debounced pads exposed through PSG I/O registers.
//   clk, reset               : system clock, synchronous active-high reset
//   tick                     : debounce sample enable
//   pad0_raw, pad1_raw       : raw active-low pad bytes
//   sel_we, sel_din          : register-select write
//   rd_req                   : one-cycle read request of the selected register
//   rd_data, rd_valid        : response (rd_data is 8'hFF outside rd_valid)
//   pad0_stable, pad1_stable : debounced pad bytes
//   pad_changed              : per-pad one-cycle update pulse
module pad_scan_ctrl
  import pad_scan_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] pad0_raw,
  input  logic [7:0] pad1_raw,
  input  logic       sel_we,
  input  logic [3:0] sel_din,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] pad0_stable,
  output logic [7:0] pad1_stable,
  output logic [1:0] pad_changed
);

  logic [3:0] sel;
  logic [3:0] sel_cap;
  logic       pending;
  rd_state_t  state;

  pad_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_pad0 (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .raw     (pad0_raw),
    .stable  (pad0_stable),
    .changed (pad_changed[0])
  );

  pad_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_pad1 (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .raw     (pad1_raw),
    .stable  (pad1_stable),
    .changed (pad_changed[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= 4'd0;
      sel_cap  <= 4'd0;
      pending  <= 1'b0;
      state    <= ST_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= PAD_IDLE;
    end else begin
      // sel_cap is sampled from the old sel, so a same-cycle write is not seen.
      if (sel_we) sel <= sel_din;
      rd_valid <= 1'b0;
      rd_data  <= PAD_IDLE;
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            sel_cap <= sel;
            state   <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          // Byte is frozen here; a stable update on this edge is not seen.
          rd_valid <= 1'b1;
          rd_data  <= resp_byte(sel_cap, pad0_stable, pad1_stable);
          state    <= ST_RESP;
          if (rd_req) pending <= 1'b1;
        end
        ST_RESP: begin
          // A request arriving now with nothing pending is taken directly.
          if (pending || rd_req) begin
            pending <= 1'b0;
            sel_cap <= sel;
            state   <= ST_SNAP;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_scan_ctrl.sv
// tb_pad_scan_ctrl: directed self-checking bench for pad_scan_ctrl (DEBOUNCE_N=4).
module tb_pad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] pad0_raw = 8'hFF;
  logic [7:0] pad1_raw = 8'hFF;
  logic       sel_we = 1'b0;
  logic [3:0] sel_din = 4'd0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] pad0_stable;
  logic [7:0] pad1_stable;
  logic [1:0] pad_changed;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pad_scan_ctrl #(.DEBOUNCE_N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .pad0_raw    (pad0_raw),
    .pad1_raw    (pad1_raw),
    .sel_we      (sel_we),
    .sel_din     (sel_din),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .pad0_stable (pad0_stable),
    .pad1_stable (pad1_stable),
    .pad_changed (pad_changed)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Apply raw bytes and give them five ticks, enough to debounce with N=4.
  task automatic load_pads(input logic [7:0] p0, input logic [7:0] p1);
    pad0_raw = p0;
    pad1_raw = p1;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic write_sel(input logic [3:0] v);
    sel_we  = 1'b1;
    sel_din = v;
    step();
    sel_we  = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (pad0_stable !== 8'hFF) begin bad++; $display("FAIL reset_pad0 got=%h exp=ff", pad0_stable); end
    total++; if (pad1_stable !== 8'hFF) begin bad++; $display("FAIL reset_pad1 got=%h exp=ff", pad1_stable); end
    total++; if (pad_changed !== 2'b00) begin bad++; $display("FAIL reset_changed got=%b exp=00", pad_changed); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'hFF) begin bad++; $display("FAIL reset_data got=%h exp=ff", rd_data); end
  endtask

  task automatic test_debounce;
    do_reset();
    pad0_raw = 8'hFD;
    for (int t = 1; t <= 4; t++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (t < 4) begin
        total++; if (pad0_stable !== 8'hFF) begin bad++; $display("FAIL deb_early tick=%0d got=%h exp=ff", t, pad0_stable); end
        total++; if (pad_changed !== 2'b00) begin bad++; $display("FAIL deb_early_chg tick=%0d got=%b exp=00", t, pad_changed); end
      end else begin
        total++; if (pad0_stable !== 8'hFD) begin bad++; $display("FAIL deb_stable got=%h exp=fd", pad0_stable); end
        total++; if (pad_changed !== 2'b01) begin bad++; $display("FAIL deb_pulse got=%b exp=01", pad_changed); end
      end
      step();
      total++; if (pad_changed !== 2'b00) begin bad++; $display("FAIL deb_pulse_width tick=%0d got=%b exp=00", t, pad_changed); end
    end
    // Holding the same value commits again but must not pulse.
    tick = 1'b1;
    step();
    tick = 1'b0;
    total++; if (pad_changed !== 2'b00) begin bad++; $display("FAIL deb_hold_chg got=%b exp=00", pad_changed); end
    total++; if (pad0_stable !== 8'hFD) begin bad++; $display("FAIL deb_hold got=%h exp=fd", pad0_stable); end
  endtask

  task automatic test_glitch;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pad0_raw = (i % 2 == 0) ? 8'hFD : 8'hFF;
      tick = 1'b1;
      step();
      tick = 1'b0;
      total++; if (pad_changed !== 2'b00) begin bad++; $display("FAIL glitch_chg i=%0d got=%b exp=00", i, pad_changed); end
      step();
    end
    total++; if (pad0_stable !== 8'hFF) begin bad++; $display("FAIL glitch_stable got=%h exp=ff", pad0_stable); end
    pad0_raw = 8'hFF;
  endtask

  task automatic test_read_iob;
    load_pads(8'hFE, 8'h7B);
    total++; if (pad1_stable !== 8'h7B) begin bad++; $display("FAIL iob_stable got=%h exp=7b", pad1_stable); end
    write_sel(4'd15);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL iob_early_valid got=%b exp=0", rd_valid); end
    step();
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL iob_valid got=%b exp=1", rd_valid); end
    total++; if (rd_data !== 8'h7B) begin bad++; $display("FAIL iob_data got=%h exp=7b", rd_data); end
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL iob_valid_width got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'hFF) begin bad++; $display("FAIL iob_data_idle got=%h exp=ff", rd_data); end
  endtask

  task automatic test_back_to_back;
    int n;
    int idx[2];
    logic [7:0] dat[2];
    n = 0;
    idx[0] = -1; idx[1] = -1;
    dat[0] = 8'h00; dat[1] = 8'h00;
    write_sel(4'd14);
    for (int c = 0; c < 10; c++) begin
      rd_req = (c < 3);
      step();
      rd_req = 1'b0;
      if (rd_valid === 1'b1) begin
        if (n < 2) begin
          idx[n] = c;
          dat[n] = rd_data;
        end
        n++;
      end
    end
    total++; if (n != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n); end
    total++; if (idx[0] != 1) begin bad++; $display("FAIL b2b_first_at got=%0d exp=1", idx[0]); end
    total++; if (idx[1] != 3) begin bad++; $display("FAIL b2b_second_at got=%0d exp=3", idx[1]); end
    total++; if (dat[0] !== 8'hFE) begin bad++; $display("FAIL b2b_data0 got=%h exp=fe", dat[0]); end
    total++; if (dat[1] !== 8'hFE) begin bad++; $display("FAIL b2b_data1 got=%h exp=fe", dat[1]); end
  endtask

  task automatic test_sel_rules;
    write_sel(4'd3);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin bad++; $display("FAIL sel3 got=%b/%h exp=1/ff", rd_valid, rd_data); end
    step();
    write_sel(4'd14);
    sel_we  = 1'b1;
    sel_din = 4'd15;
    rd_req  = 1'b1;
    step();
    sel_we = 1'b0;
    rd_req = 1'b0;
    step();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hFE) begin bad++; $display("FAIL same_cycle_sel got=%b/%h exp=1/fe", rd_valid, rd_data); end
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h7B) begin bad++; $display("FAIL new_sel got=%b/%h exp=1/7b", rd_valid, rd_data); end
    step();
  endtask

  task automatic test_reset_mid_read;
    int seen;
    seen = 0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'hFF) begin bad++; $display("FAIL rst_mid_data got=%h exp=ff", rd_data); end
    total++; if (pad0_stable !== 8'hFF || pad1_stable !== 8'hFF) begin bad++; $display("FAIL rst_mid_stable got=%h/%h exp=ff/ff", pad0_stable, pad1_stable); end
    total++; if (pad_changed !== 2'b00) begin bad++; $display("FAIL rst_mid_chg got=%b exp=00", pad_changed); end
    for (int c = 0; c < 4; c++) begin
      step();
      if (rd_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_late_valid got=%0d exp=0", seen); end
    // Pads not yet debounced after reset: sel 14 still reads the idle byte.
    write_sel(4'd14);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin bad++; $display("FAIL first_read got=%b/%h exp=1/ff", rd_valid, rd_data); end
    step();
  endtask

  task automatic test_freeze;
    do_reset();
    pad0_raw = 8'hFD;
    for (int t = 0; t < 3; t++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    write_sel(4'd14);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    tick   = 1'b1;
    step();
    tick = 1'b0;
    total++; if (pad0_stable !== 8'hFD) begin bad++; $display("FAIL freeze_stable got=%h exp=fd", pad0_stable); end
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin bad++; $display("FAIL freeze_data got=%b/%h exp=1/ff", rd_valid, rd_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_read_iob();
    test_back_to_back();
    test_sel_rules();
    test_reset_mid_read();
    test_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
